// File: rtl/rram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rram_ctrl_pkg
// Purpose  : Opcodes, FSM states and instruction field positions shared by
//            the RRAM controller and its sub-blocks.
// Revision : 1.0
// ============================================================================
package rram_ctrl_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LOAD   = 4'h1;
   localparam logic [3:0] OP_SETBIT = 4'h2;
   localparam logic [3:0] OP_MAC    = 4'h3;
   localparam logic [3:0] OP_CLRACC = 4'h4;
   localparam logic [3:0] OP_HALT   = 4'hF;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int COL_MSB = 27;
   localparam int COL_LSB = 24;
   localparam int ROW_MSB = 23;
   localparam int ROW_LSB = 20;
   localparam int VAL_BIT = 0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rram_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rram_ctrl_fifo
// Purpose  : Count-based synchronous FIFO with registered empty/full flags.
// Revision : 1.0
// ============================================================================
module rram_ctrl_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             push_ok;
   logic             pop_ok;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == (AW+1)'(DEPTH));
      end
   end

endmodule
`default_nettype wire

// File: rtl/rram_controller.sv
`default_nettype none
// ============================================================================
// Module   : rram_controller
// Purpose  : Instruction-driven controller for a 16x16 RRAM compute array.
//            Optional debug outputs enabled by RRAM_CTRL_DEBUG_EN.
// Revision : 1.0
// ============================================================================
module rram_controller
   import rram_ctrl_pkg::*;
#(
   parameter int INSTRUCTION_SIZE = 32,
   parameter int ARRAY_SIZE       = 16,
   parameter int ADDR_SIZE_IM     = 7,
   parameter int IB_DEPTH         = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wishbone_wr_cs_instruction_memory,
   input  logic                        wishbone_wr_en_instruction_memory,
   input  logic [INSTRUCTION_SIZE-1:0] wishbone_data_in_instruction_memory,
   output logic                        wishbone_empty_instruction_memory,
   output logic                        wishbone_full_instruction_memory,
   input  logic                        wishbone_wr_cs_input_buffer,
   input  logic                        wishbone_wr_en_input_buffer,
   input  logic [ARRAY_SIZE-1:0]       wishbone_data_in_input_buffer,
   output logic                        wishbone_empty_input_buffer,
   output logic                        wishbone_full_input_buffer,
   input  logic                        enable_PC_IM,
   input  logic [ADDR_SIZE_IM-1:0]     start_PC_IM_address
`ifdef RRAM_CTRL_DEBUG_EN
   ,
   output logic [ADDR_SIZE_IM-1:0]     dbg_pc,
   output logic [2:0]                  dbg_state,
   output logic [7:0]                  dbg_acc,
   output logic [ARRAY_SIZE-1:0]       dbg_array_row
`endif
);

   localparam int                    IM_DEPTH      = 1 << ADDR_SIZE_IM;
   localparam logic [ADDR_SIZE_IM:0] IM_FULL_COUNT = IM_DEPTH[ADDR_SIZE_IM:0];
   localparam logic [ADDR_SIZE_IM-1:0] ADDR_ONE    = 1;

   logic [INSTRUCTION_SIZE-1:0] im_mem [IM_DEPTH];
   logic [ADDR_SIZE_IM-1:0]     im_wr_ptr;
   logic [ADDR_SIZE_IM:0]       im_count;
   logic [ADDR_SIZE_IM:0]       im_count_next;
   logic                        im_we;

   logic [ARRAY_SIZE-1:0]       arr [ARRAY_SIZE];
   logic [7:0]                  acc;
   logic [ADDR_SIZE_IM-1:0]     pc;
   logic [INSTRUCTION_SIZE-1:0] ir;
   logic [3:0]                  op;
   logic [3:0]                  row;
   logic [3:0]                  col;
   logic                        setval;
   logic                        enable_q;
   state_t                      state;
   state_t                      next_state;

   logic                        pc_load;
   logic                        pc_adv;
   logic                        ib_pop;
   logic                        do_setbit;
   logic                        do_clr;
   logic [ARRAY_SIZE-1:0]       ib_dout;
   logic                        ib_empty;
   logic                        unused_reserved;

   function automatic logic [7:0] popcount(input logic [ARRAY_SIZE-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

   assign unused_reserved = ^ir[ROW_LSB-1:VAL_BIT+1];

   assign im_we         = wishbone_wr_cs_instruction_memory && wishbone_wr_en_instruction_memory &&
                          !wishbone_full_instruction_memory;
   assign im_count_next = im_count + {{ADDR_SIZE_IM{1'b0}}, im_we};

   // A fetch from the address being written this cycle still sees the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IM_DEPTH; i++) begin
            im_mem[i] <= '0;
         end
         im_wr_ptr                         <= '0;
         im_count                          <= '0;
         wishbone_empty_instruction_memory <= 1'b1;
         wishbone_full_instruction_memory  <= 1'b0;
      end else begin
         if (im_we) begin
            im_mem[im_wr_ptr] <= wishbone_data_in_instruction_memory;
            im_wr_ptr         <= im_wr_ptr + ADDR_ONE;
         end
         im_count                          <= im_count_next;
         wishbone_empty_instruction_memory <= (im_count_next == '0);
         wishbone_full_instruction_memory  <= (im_count_next == IM_FULL_COUNT);
      end
   end

   rram_ctrl_fifo #(
      .WIDTH (ARRAY_SIZE),
      .DEPTH (IB_DEPTH)
   ) u_ib (
      .clk   (clk),
      .rst   (rst),
      .push  (wishbone_wr_cs_input_buffer && wishbone_wr_en_input_buffer),
      .pop   (ib_pop),
      .din   (wishbone_data_in_input_buffer),
      .dout  (ib_dout),
      .empty (ib_empty),
      .full  (wishbone_full_input_buffer)
   );

   assign wishbone_empty_input_buffer = ib_empty;

   always_comb begin
      next_state = state;
      pc_load    = 1'b0;
      pc_adv     = 1'b0;
      ib_pop     = 1'b0;
      do_setbit  = 1'b0;
      do_clr     = 1'b0;
      if (!enable_PC_IM && state != S_IDLE) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable_PC_IM && !enable_q) begin
                  next_state = S_FETCH;
                  pc_load    = 1'b1;
               end
            end
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
               next_state = S_FETCH;
               pc_adv     = 1'b1;
               case (op)
                  OP_LOAD, OP_MAC: begin
                     if (ib_empty) begin
                        next_state = S_EXEC;
                        pc_adv     = 1'b0;
                     end else begin
                        ib_pop = 1'b1;
                     end
                  end
                  OP_SETBIT: do_setbit = 1'b1;
                  OP_CLRACC: do_clr    = 1'b1;
                  OP_HALT: begin
                     next_state = S_HALT;
                     pc_adv     = 1'b0;
                  end
                  OP_NOP:  ;
                  default: ;
               endcase
            end
            S_HALT:  ;
            default: next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         enable_q <= 1'b0;
         pc       <= '0;
         ir       <= '0;
         op       <= '0;
         row      <= '0;
         col      <= '0;
         setval   <= 1'b0;
         acc      <= '0;
         for (int r = 0; r < ARRAY_SIZE; r++) begin
            arr[r] <= '0;
         end
      end else begin
         state    <= next_state;
         enable_q <= enable_PC_IM;
         if (pc_load) begin
            pc <= start_PC_IM_address;
         end else if (pc_adv) begin
            pc <= pc + ADDR_ONE;
         end
         if (state == S_FETCH) begin
            ir <= im_mem[pc];
         end
         if (state == S_DECODE) begin
            op     <= ir[OPC_MSB:OPC_LSB];
            col    <= ir[COL_MSB:COL_LSB];
            row    <= ir[ROW_MSB:ROW_LSB];
            setval <= ir[VAL_BIT];
         end
         if (ib_pop && op == OP_LOAD) begin
            arr[row] <= ib_dout;
         end
         if (do_setbit) begin
            arr[row][col] <= setval;
         end
         if (ib_pop && op == OP_MAC) begin
            acc <= acc + popcount(arr[row] & ib_dout);
         end else if (do_clr) begin
            acc <= '0;
         end
      end
   end

`ifdef RRAM_CTRL_DEBUG_EN
   assign dbg_pc        = pc;
   assign dbg_state     = state;
   assign dbg_acc       = acc;
   assign dbg_array_row = arr[ir[ROW_MSB:ROW_LSB]];
`endif

endmodule
`default_nettype wire

// File: tb/tb_rram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rram_controller
// Purpose  : Scoreboard bench for rram_controller with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rram_controller;
   import rram_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        im_cs = 1'b0, im_en = 1'b0;
   logic [31:0] im_data = '0;
   logic        im_empty, im_full;
   logic        ib_cs = 1'b0, ib_en = 1'b0;
   logic [15:0] ib_data = '0;
   logic        ib_empty, ib_full;
   logic        enable = 1'b0;
   logic [6:0]  start_addr = '0;
`ifdef RRAM_CTRL_DEBUG_EN
   logic [6:0]  dbg_pc;
   logic [2:0]  dbg_state;
   logic [7:0]  dbg_acc;
   logic [15:0] dbg_array_row;
`endif

   always #5 clk = ~clk;

   rram_controller dut (
      .clk                                 (clk),
      .rst                                 (rst),
      .wishbone_wr_cs_instruction_memory   (im_cs),
      .wishbone_wr_en_instruction_memory   (im_en),
      .wishbone_data_in_instruction_memory (im_data),
      .wishbone_empty_instruction_memory   (im_empty),
      .wishbone_full_instruction_memory    (im_full),
      .wishbone_wr_cs_input_buffer         (ib_cs),
      .wishbone_wr_en_input_buffer         (ib_en),
      .wishbone_data_in_input_buffer       (ib_data),
      .wishbone_empty_input_buffer         (ib_empty),
      .wishbone_full_input_buffer          (ib_full),
      .enable_PC_IM                        (enable),
      .start_PC_IM_address                 (start_addr)
`ifdef RRAM_CTRL_DEBUG_EN
      ,
      .dbg_pc                              (dbg_pc),
      .dbg_state                           (dbg_state),
      .dbg_acc                             (dbg_acc),
      .dbg_array_row                       (dbg_array_row)
`endif
   );

   typedef struct packed {
      logic [255:0] arr;
      logic [7:0]   acc;
      logic [6:0]   pc;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] prog [128];
   int          prog_n = 0;
   logic [15:0] ibw[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference interpreter: runs the program from 'start' until HALT.
   task automatic model_run(input int start, output exp_t e, output int pops);
      logic [15:0] a [16];
      logic [7:0]  accm;
      logic [31:0] w;
      logic [3:0]  opm, rowm, colm;
      int          pcm;
      accm = '0;
      pcm  = start;
      pops = 0;
      for (int i = 0; i < 16; i++) a[i] = '0;
      for (int step = 0; step < 1024; step++) begin
         w    = prog[pcm];
         opm  = w[31:28];
         colm = w[27:24];
         rowm = w[23:20];
         if (opm == 4'hF) break;
         if (opm == 4'h1) begin
            a[rowm] = ibw[pops];
            pops++;
         end else if (opm == 4'h2) begin
            a[rowm][colm] = w[0];
         end else if (opm == 4'h3) begin
            accm = accm + 8'($countones(a[rowm] & ibw[pops]));
            pops++;
         end else if (opm == 4'h4) begin
            accm = '0;
         end
         pcm = (pcm + 1) % 128;
      end
      e.pc  = 7'(pcm);
      e.acc = accm;
      for (int i = 0; i < 16; i++) e.arr[i*16 +: 16] = a[i];
   endtask

   // Monitor: each entry into HALT is one DUT response to score.
   exp_t         mon_e;
   logic [255:0] mon_arr;
   logic         in_halt = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         in_halt = 1'b0;
      end else if (dut.state == S_HALT) begin
         if (!in_halt) begin
            in_halt = 1'b1;
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_halt: got HALT at pc %0h expected no halt", dut.pc);
            end else begin
               mon_e = exp_q.pop_front();
               for (int i = 0; i < 16; i++) mon_arr[i*16 +: 16] = dut.arr[i];
               check("halt_pc", 32'(dut.pc), 32'(mon_e.pc));
               check("halt_acc", 32'(dut.acc), 32'(mon_e.acc));
               check_wide("halt_array", mon_arr, mon_e.arr);
               check("halt_ib_empty", 32'(ib_empty), 32'd1);
            end
         end
      end else begin
         in_halt = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      for (int i = 0; i < 128; i++) prog[i] = '0;
      prog_n = 0;
      ibw.delete();
   endtask

   task automatic im_write(input logic [31:0] w);
      im_cs = 1'b1; im_en = 1'b1; im_data = w;
      tick();
      im_cs = 1'b0; im_en = 1'b0;
      if (prog_n < 128) begin
         prog[prog_n] = w;
         prog_n++;
      end
   endtask

   task automatic ib_push(input logic [15:0] w);
      ib_cs = 1'b1; ib_en = 1'b1; ib_data = w;
      tick();
      ib_cs = 1'b0; ib_en = 1'b0;
   endtask

   task automatic launch(input int start, output int pops);
      exp_t e;
      model_run(start, e, pops);
      exp_q.push_back(e);
      start_addr = 7'(start);
      enable     = 1'b1;
   endtask

   task automatic finish_run(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         errors++;
         $display("FAIL %s_timeout: got no HALT expected HALT within %0d cycles", name, budget);
         exp_q.delete();
      end
      enable = 1'b0;
      tick();
      check({name, "_idle"}, 32'(dut.state), 32'(S_IDLE));
   endtask

   initial begin
      int          pops, n, nl, len, start;
      logic [3:0]  opr;
      logic [31:0] w;
      logic [3:0]  optab [7];
      optab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hA};

      // Reset state
      do_reset();
      check("rst_im_empty", 32'(im_empty), 32'd1);
      check("rst_im_full", 32'(im_full), 32'd0);
      check("rst_ib_empty", 32'(ib_empty), 32'd1);
      check("rst_ib_full", 32'(ib_full), 32'd0);
      check("rst_state", 32'(dut.state), 32'(S_IDLE));
      check("rst_pc", 32'(dut.pc), 32'd0);
`ifdef RRAM_CTRL_DEBUG_EN
      check("rst_dbg_state", 32'(dbg_state), 32'd0);
      check("rst_dbg_pc", 32'(dbg_pc), 32'd0);
`endif

      // IM fill + PC wrap: HALT at 0, NOP-class words elsewhere
      for (int i = 0; i < 128; i++) begin
         if (i == 0) w = 32'hF000_0000;
         else w = {4'($urandom_range(5, 14)), 8'h00, 20'($urandom)};
         if (i % 3 == 1) w[31:28] = 4'h0;
         im_write(w);
         if (i == 126) begin
            check("im_127_empty", 32'(im_empty), 32'd0);
            check("im_127_full", 32'(im_full), 32'd0);
         end
      end
      check("im_128_full", 32'(im_full), 32'd1);
      im_write(32'h2510_0001);
      check("im_129_full", 32'(im_full), 32'd1);
      check("im_129_empty", 32'(im_empty), 32'd0);
      check("im_129_count", 32'(dut.im_count), 32'd128);
      launch(127, pops);
      finish_run(40, "wrap");

      // Dropping enable mid-run returns to IDLE on the next edge
      start_addr = 7'd1;
      enable     = 1'b1;
      repeat (20) tick();
      check("midrun_busy", 32'(dut.state != S_IDLE), 32'd1);
      enable = 1'b0;
      tick();
      check("midrun_idle", 32'(dut.state), 32'(S_IDLE));

      // IB fill, overflow drop, then 16 LOADs drain it
      do_reset();
      for (int i = 0; i < 16; i++) begin
         w[15:0] = 16'($urandom);
         ibw.push_back(w[15:0]);
         ib_push(w[15:0]);
      end
      check("ib16_full", 32'(ib_full), 32'd1);
      check("ib16_empty", 32'(ib_empty), 32'd0);
      ib_push(16'($urandom));
      check("ib17_full", 32'(ib_full), 32'd1);
      check("ib17_count", 32'(dut.u_ib.count), 32'd16);
      for (int i = 0; i < 16; i++) im_write({4'h1, 4'($urandom), 4'(i), 20'($urandom)});
      im_write(32'hF000_0000);
      launch(0, pops);
      n = 0;
      while (ib_full && n < 12) begin
         tick();
         n++;
      end
      check("ib_first_pop_full", 32'(ib_full), 32'd0);
      finish_run(120, "ibload");

      // Reference program at address 2
      do_reset();
      im_write(32'h0000_0000);
      im_write(32'h0000_0000);
      im_write(32'h2510_0001);
      im_write(32'h1030_0000);
      im_write(32'h3030_0000);
      im_write(32'h0000_0000);
      im_write(32'hF000_0000);
      ibw.push_back(16'h00FF);
      ibw.push_back(16'h0F0F);
      ib_push(16'h00FF);
      ib_push(16'h0F0F);
      launch(2, pops);
      finish_run(40, "prog2");

      // MAC stall on empty IB
      do_reset();
      im_write(32'h1020_0000);
      im_write(32'h3020_0000);
      im_write(32'hF000_0000);
      w[15:0] = 16'($urandom);
      ibw.push_back(w[15:0]);
      ibw.push_back(16'hFFFF);
      ib_push(w[15:0]);
      launch(0, pops);
      n = 0;
      while (!(dut.state == S_EXEC && dut.pc == 7'd1) && n < 30) begin
         tick();
         n++;
      end
      repeat (5) tick();
      check("stall_state", 32'(dut.state), 32'(S_EXEC));
      check("stall_pc", 32'(dut.pc), 32'd1);
      ib_push(16'hFFFF);
      finish_run(30, "stall");

      // Randomized programs; IB words pushed while the program runs
      for (int iter = 0; iter < 12; iter++) begin
         do_reset();
         len = $urandom_range(4, 30);
         nl  = 0;
         for (int k = 0; k < len - 1; k++) begin
            opr = optab[$urandom_range(0, 6)];
            if ((opr == 4'h1 || opr == 4'h3) && nl >= 16) opr = 4'h2;
            if (opr == 4'h1 || opr == 4'h3) nl++;
            im_write({opr, 4'($urandom), 4'($urandom), 20'($urandom)});
         end
         im_write({4'hF, 28'($urandom)});
         for (int i = 0; i < 16; i++) ibw.push_back(16'($urandom));
         start = $urandom_range(0, len - 1);
         launch(start, pops);
         for (int i = 0; i < pops; i++) ib_push(ibw[i]);
         finish_run(3 * len + 60, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
